dna_seq_loader: RTL and testbench
=================================

# dna_seq_loader

Upstream loader for the DNA register file. Accepts an ASCII nucleotide byte stream over a valid/ready handshake and packs each base into a 2-bit code, `DATA_WIDTH/2` bases per word. Each completed word goes out on a write port that drives the register file's `w_en` / `w_addr` / `w_data` directly. The block reports base and word counts, a completion pulse, and sticky error flags so the consuming logic knows how much of the memory holds valid sequence.

## Interface
- `DATA_WIDTH`, 32: word width; must be even. Bases per word BPW = `DATA_WIDTH/2`.
- `DEPTH`, 128: number of words in the target register file; addresses run 0..DEPTH-1.
- `clk` input 1: single clock; all logic on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low. This is the block's one clock and reset.
- `start` input 1: one-cycle pulse; begins a new load. Honoured only in IDLE.
- `s_valid` input 1: byte on `s_data` is valid.
- `s_data` input 8: ASCII character.
- `s_ready` output 1: block accepts the byte this cycle. Equals (state == LOAD).
- `w_en` output 1: register-file write strobe.
- `w_addr` output 32: register-file write address, zero-extended word index.
- `w_data` output DATA_WIDTH: packed word.
- `base_count` output 16: bases accepted and stored in the current/last load.
- `word_count` output 8: words written in the current/last load.
- `done` output 1: one-cycle pulse at load completion.
- `busy` output 1: state != IDLE.
- `err_char` output 1: sticky; an unrecognised character was dropped.
- `overflow` output 1: sticky; bases arrived after DEPTH words were filled.

## Operation
- States:
  - IDLE: waits for `start`.
  - LOAD: accepts characters.
  - FLUSH: writes the partial word.
  - DONE: pulses `done`.
- IDLE -> LOAD on `start`. On entry, clear the shift register, the in-word index k, the word index, both counts, `err_char` and `overflow`.
- In LOAD, each accepted byte (`s_valid` && `s_ready`) is classified:
  - Base codes: 'A'/'a' -> 00, 'C'/'c' -> 01, 'G'/'g' -> 10, 'T'/'t' -> 11.
  - 0x0D (CR): ignored silently, nothing counted.
  - 0x0A (LF): terminator. Go to FLUSH if k != 0, else to DONE.
  - Any other byte: dropped, `err_char` <= 1.
- Packing: base k of a word lands at bits [2k+1:2k], so the first base is at the LSBs. Unfilled upper bits of a flushed word are 0.
- When the base making k == BPW is accepted:
  - Issue a write of the completed word at the current word index.
  - Increment the word index and reset k to 0.
  - No stall; LOAD keeps accepting one byte per cycle.
- Full condition: word index == DEPTH. Any further base is dropped, not counted, and sets `overflow` <= 1. Terminators and CR are still processed.
- FLUSH: issue one write of the partial word, increment `word_count`, then go to DONE.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
- `base_count`, `word_count`, `err_char` and `overflow` hold their values in IDLE until the next `start`.
- `start` while not in IDLE is ignored.
- Register-file contents are never cleared by this block.

## Timing
- Reset values:
  - State is IDLE.
  - `s_ready`, `w_en`, `done`, `busy`, `err_char` and `overflow` are 0.
  - `w_addr`, `w_data`, `base_count` and `word_count` are 0.
- Reset mid-load aborts immediately. No further writes are issued, and any partial word is lost.
- `w_en`, `w_addr` and `w_data` are registered. `w_en` is high for exactly one cycle: the cycle after the handshake that completed the word, or the cycle after FSM entry to FLUSH. `w_addr` and `w_data` are valid when `w_en` = 1.
- `base_count` and `word_count` update in the cycle after the event that changes them.
- From terminator accept to `done` high:
  - With a partial word (via FLUSH): 2 cycles. The flush `w_en` is 1 cycle after the terminator accept; `done` is the cycle after that.
  - With k == 0: 1 cycle.
- `s_ready` is low from the cycle after the terminator accept until the next `start` has been taken.
- Sustained throughput: 1 byte per clock, with no bubbles in LOAD.

## Test plan
- `start`, then "ACGT\n" back-to-back:
  - One write, `w_addr`=0, `w_data`=0x000000E4.
  - `done` 2 cycles after the LF accept; `base_count`=4, `word_count`=1.
- `start`, then 16×'T' followed by "\n":
  - `w_en` the cycle after the 16th accept, `w_addr`=0, `w_data`=0xFFFFFFFF.
  - No flush write; `done` 1 cycle after LF; `word_count`=1, `base_count`=16.
- `start`, then "aXc\r\n":
  - `err_char`=1, `w_data`=0x00000004, `base_count`=2.
  - CR leaves no trace.
- `start`, then 2049×'G' and "\n":
  - 128 writes to addresses 0..127, each 0xAAAAAAAA.
  - `overflow`=1, `base_count`=2048, `word_count`=128, no flush write.
- `start`, then 10 bases, then `rst_n` low for 1 cycle:
  - No `w_en` ever fires and all outputs read 0.
  - A new `start` followed by "C\n" writes `w_addr`=0, `w_data`=0x1.
- Randomised `s_valid` gaps plus a `start` pulse during LOAD:
  - Packed data is identical to the gap-free run.
  - The extra `start` has no effect on counts or addresses.

Source files
------------

// File: rtl/dna_seq_loader.sv
// Packs an ASCII nucleotide stream into 2-bit codes, DATA_WIDTH/2 bases per register-file word.
// Latency: word write 1 cycle after the completing byte; done 1 cycle (k==0) or 2 cycles (partial word) after LF.
// Backpressure: s_ready is high only in LOAD; one byte per clock with no bubbles.
module dna_seq_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  w_en,
    output logic [31:0]           w_addr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic [15:0]           base_count,
    output logic [7:0]            word_count,
    output logic                  done,
    output logic                  busy,
    output logic                  err_char,
    output logic                  overflow
);

    localparam int BPW = DATA_WIDTH / 2;
    localparam int KW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int WIW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE
    } state_t;

    state_t                state;
    logic [KW-1:0]         k;
    logic [WIW-1:0]        word_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_ins;
    logic                  is_base;
    logic                  is_cr;
    logic                  is_lf;
    logic [1:0]            code;
    logic                  full;
    logic                  last_in_word;

    assign s_ready      = (state == ST_LOAD);
    assign busy         = (state != ST_IDLE);
    assign done         = (state == ST_DONE);
    assign full         = (word_idx == WIW'(DEPTH));
    assign last_in_word = (k == KW'(BPW - 1));

    always_comb begin
        is_base = 1'b1;
        is_cr   = 1'b0;
        is_lf   = 1'b0;
        code    = 2'b00;
        case (s_data)
            8'h41, 8'h61: code = 2'b00;
            8'h43, 8'h63: code = 2'b01;
            8'h47, 8'h67: code = 2'b10;
            8'h54, 8'h74: code = 2'b11;
            8'h0D: begin is_base = 1'b0; is_cr = 1'b1; end
            8'h0A: begin is_base = 1'b0; is_lf = 1'b1; end
            default: is_base = 1'b0;
        endcase
        // First base of a word sits in the LSBs.
        shreg_ins = shreg;
        shreg_ins[{k, 1'b0} +: 2] = code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            k          <= '0;
            word_idx   <= '0;
            shreg      <= '0;
            w_en       <= 1'b0;
            w_addr     <= '0;
            w_data     <= '0;
            base_count <= '0;
            word_count <= '0;
            err_char   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            w_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_LOAD;
                        k          <= '0;
                        word_idx   <= '0;
                        shreg      <= '0;
                        base_count <= '0;
                        word_count <= '0;
                        err_char   <= 1'b0;
                        overflow   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (s_valid) begin
                        if (is_base) begin
                            if (full) begin
                                overflow <= 1'b1;
                            end else begin
                                base_count <= base_count + 16'd1;
                                if (last_in_word) begin
                                    w_en       <= 1'b1;
                                    w_addr     <= 32'(word_idx);
                                    w_data     <= shreg_ins;
                                    word_idx   <= word_idx + WIW'(1);
                                    word_count <= word_count + 8'd1;
                                    k          <= '0;
                                    shreg      <= '0;
                                end else begin
                                    shreg <= shreg_ins;
                                    k     <= k + KW'(1);
                                end
                            end
                        end else if (is_lf) begin
                            // The partial-word write is issued on the edge that enters FLUSH.
                            if (k != '0) begin
                                w_en       <= 1'b1;
                                w_addr     <= 32'(word_idx);
                                w_data     <= shreg;
                                word_idx   <= word_idx + WIW'(1);
                                word_count <= word_count + 8'd1;
                                state      <= ST_FLUSH;
                            end else begin
                                state <= ST_DONE;
                            end
                        end else if (!is_cr) begin
                            err_char <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: state <= ST_DONE;
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dna_seq_loader.sv
// Table-driven bench for dna_seq_loader with a write scoreboard fed by a packing model.
module tb_dna_seq_loader;

    localparam int DW    = 32;
    localparam int DEPTH = 128;
    localparam int BPW   = DW / 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = 8'h00;
    logic          s_ready;
    logic          w_en;
    logic [31:0]   w_addr;
    logic [DW-1:0] w_data;
    logic [15:0]   base_count;
    logic [7:0]    word_count;
    logic          done;
    logic          busy;
    logic          err_char;
    logic          overflow;

    always #5 clk = ~clk;

    dna_seq_loader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .base_count(base_count), .word_count(word_count), .done(done), .busy(busy),
        .err_char(err_char), .overflow(overflow)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        string       seq;
        bit          gaps;
        int          bases;
        int          words;
        bit          err;
        bit          ovf;
        logic [31:0] w0;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_q[$];
    int          m_k;
    int          m_word;
    logic [31:0] m_sh;
    bit          first_seen;
    logic [31:0] first_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && w_en === 1'b1) begin
            chk("write_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("w_addr", 64'(w_addr), 64'(e.addr));
                chk("w_data", 64'(w_data), 64'(e.data));
            end
            if (!first_seen) begin
                first_seen = 1'b1;
                first_data = w_data;
            end
        end
    end

    task automatic model_byte(input logic [7:0] b, output bit wr, output bit term, output bit flush);
        bit       isb;
        logic [1:0] c;
        wr = 0; term = 0; flush = 0; isb = 1; c = 2'b00;
        case (b)
            "A", "a": c = 2'b00;
            "C", "c": c = 2'b01;
            "G", "g": c = 2'b10;
            "T", "t": c = 2'b11;
            8'h0A: begin isb = 0; term = 1; end
            default: isb = 0;
        endcase
        if (isb && m_word < DEPTH) begin
            m_sh[2*m_k +: 2] = c;
            m_k++;
            if (m_k == BPW) begin
                exp_q.push_back('{32'(m_word), m_sh});
                m_word++;
                m_k  = 0;
                m_sh = '0;
                wr   = 1;
            end
        end
        if (term && m_k != 0) begin
            exp_q.push_back('{32'(m_word), m_sh});
            m_word++;
            wr    = 1;
            flush = 1;
        end
    endtask

    task automatic do_start();
        m_k = 0; m_word = 0; m_sh = '0; first_seen = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("s_ready_after_start", 64'(s_ready), 64'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit term);
        bit wr, flush;
        int n;
        term = 0;
        s_data  = b;
        s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 50) begin
            chk("s_ready_timeout", 64'(s_ready), 64'd1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        model_byte(b, wr, term, flush);
        chk("w_en_timing", 64'(w_en), 64'(wr));
        if (term) begin
            s_valid = 1'b0;
            chk("done_after_lf", 64'(done), 64'(!flush));
            if (flush) begin
                @(posedge clk); #1;
                chk("done_after_flush", 64'(done), 64'd1);
            end
            @(posedge clk); #1;
            chk("done_single_cycle", 64'(done), 64'd0);
            chk("idle_ready_busy", 64'({s_ready, busy}), 64'd0);
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit term;
        do_start();
        for (int i = 0; i < v.seq.len(); i++) begin
            if (v.gaps) begin
                s_valid = 1'b0;
                if (i == 5) start = 1'b1;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                    start = 1'b0;
                end
            end
            send_byte(v.seq[i], term);
        end
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("base_count", 64'(base_count), 64'(v.bases));
        chk("word_count", 64'(word_count), 64'(v.words));
        chk("err_char", 64'(err_char), 64'(v.err));
        chk("overflow", 64'(overflow), 64'(v.ovf));
        chk("first_word", 64'(first_data), 64'(v.w0));
        chk("writes_drained", 64'(exp_q.size()), 64'd0);
    endtask

    vec_t  vt[6];
    string tseq;
    string gseq;

    initial begin
        bit term;
        tseq = "";
        for (int i = 0; i < 16; i++) tseq = {tseq, "T"};
        gseq = "";
        for (int i = 0; i < 2049; i++) gseq = {gseq, "G"};
        vt[0] = '{"ACGT\n",                  0, 4,    1,   0, 0, 32'h000000E4};
        vt[1] = '{{tseq, "\n"},              0, 16,   1,   0, 0, 32'hFFFFFFFF};
        vt[2] = '{"aXc\r\n",                 0, 2,    1,   1, 0, 32'h00000004};
        vt[3] = '{{gseq, "\n"},              0, 2048, 128, 0, 1, 32'hAAAAAAAA};
        vt[4] = '{"GATTACAgattacaCCGGTT\n",  0, 20,   2,   0, 0, 32'h513C84F2};
        vt[5] = '{"GATTACAgattacaCCGGTT\n",  1, 20,   2,   0, 0, 32'h513C84F2};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", 64'({s_ready, w_en, done, busy, err_char, overflow}), 64'd0);
        chk("reset_data", {w_addr, w_data}, 64'd0);
        chk("reset_counts", 64'({base_count, word_count}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // Abort a load mid-word with reset; nothing may be written.
        do_start();
        for (int i = 0; i < 10; i++) send_byte("A", term);
        s_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_ctrl", 64'({s_ready, w_en, done, busy, err_char, overflow}), 64'd0);
        chk("abort_data", {w_addr, w_data}, 64'd0);
        chk("abort_counts", 64'({base_count, word_count}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec('{"C\n", 0, 1, 1, 0, 0, 32'h00000001});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
